stq_commit_sequencer: RTL and testbench
=======================================

Name: stq_commit_sequencer

Overview:
- Drains retired stores from the store queue head, one at a time, into the data memory write port.
- For each store written, drives one commit pulse (stq_commit, stq_commit_index) into the LSU order-failure searcher.
- Samples the searcher's per-load failure vector the same cycle and raises a load-queue flush request naming the oldest failing load. Holds off further commits until the flush is acknowledged.

Parameters:
XLEN, 32, data/address width
LDQ_SIZE, 32, load queue entries; power of two
STQ_SIZE, 32, store queue entries; power of two

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- stq_head  input  $clog2(STQ_SIZE)  current STQ head index
- stq_head_valid  input  1  head entry occupied
- stq_head_retired  input  1  ROB has retired the head store
- stq_head_address  input  XLEN  head store address
- stq_head_data  input  XLEN  head store data
- stq_pop  output  1  one-cycle pulse; STQ advances head next edge
- mem_wr_valid  output  1  write request
- mem_wr_ready  input  1  memory accepts write
- mem_wr_addr  output  XLEN  latched store address
- mem_wr_data  output  XLEN  latched store data
- stq_commit  output  1  commit pulse to searcher
- stq_commit_index  output  $clog2(STQ_SIZE)  latched committing index
- order_failures  input  LDQ_SIZE  searcher result, combinational from stq_commit
- ldq_head  input  $clog2(LDQ_SIZE)  oldest load index
- ldq_flush_valid  output  1  flush request
- ldq_flush_index  output  $clog2(LDQ_SIZE)  oldest failing load; flush it and all younger
- ldq_flush_ack  input  1  flush accepted
- busy  output  1  state != IDLE
- order_failure_count  output  16  saturating count of flush events

Behaviour:
- States: IDLE, WRITE, CHECK, FLUSH. Reset -> IDLE.
- Reset values: all outputs 0; latched index/address/data 0; order_failure_count 0.
- IDLE:
  - If stq_head_valid && stq_head_retired, latch stq_head, address and data, then go to WRITE.
  - Otherwise stay in IDLE.
- WRITE:
  - mem_wr_valid=1; addr/data come from the latches and are stable while valid is high.
  - Valid stays high until the cycle mem_wr_ready=1 (the handshake). Next state is CHECK.
  - There is no timeout; the controller waits indefinitely.
- CHECK, exactly one cycle:
  - stq_commit=1 and stq_pop=1; stq_commit_index = latched index.
  - If |order_failures: register ldq_flush_index, increment order_failure_count (saturate at 16'hFFFF), go to FLUSH.
  - Otherwise go to IDLE.
- Oldest-failure select: among set bits i of order_failures, choose the minimum of (i - ldq_head) mod LDQ_SIZE. The subtraction is $clog2(LDQ_SIZE) bits with natural wrap. Ties are impossible.
- FLUSH:
  - ldq_flush_valid=1; ldq_flush_index is held.
  - On ldq_flush_ack go to IDLE, and ldq_flush_valid drops the next cycle.
  - An ack arriving in the same cycle valid first rises is legal.
- Throughput: one store per 3 cycles minimum (IDLE->WRITE->CHECK->IDLE) with ready held high.
- Head changes while in WRITE or CHECK are ignored; only the latched values are used.
- stq_commit and stq_pop are never asserted outside CHECK.
- Index wrap: a latched index of STQ_SIZE-1 is passed through unchanged. Wrap is the STQ's responsibility.
- A head_retired deassertion after latching has no effect; retired stores are architectural and always complete.
- Asynchronous reset mid-operation: return to IDLE immediately and drop mem_wr_valid / ldq_flush_valid. The in-flight store is abandoned and no pop is issued.

Test Plan:
- Single store: head=5 valid+retired, addr=0x100, data=0xDEADBEEF, ready=1, order_failures=0 -> mem_wr_valid for 1 cycle with those values; next cycle stq_commit=1, index=5, stq_pop=1; then IDLE; no flush.
- Backpressure: ready low for 4 cycles -> mem_wr_valid held 5 cycles with stable addr/data; stq_commit only after the handshake; change stq_head during the stall -> commit index still the latched value.
- Failure select with wrap: ldq_head=30 (LDQ_SIZE=32), order_failures bits {2,31} set in CHECK -> ldq_flush_index=31; ldq_flush_valid held until ack; order_failure_count=1.
- Back-to-back: 3 retired stores, ready=1 -> commits at cycles 2, 5, 8 relative to the first latch; exactly 3 stq_pop pulses.
- Flush blocking: failure raised, ack withheld 10 cycles with a retired head present -> no mem_wr_valid until the cycle after ack.
- Reset mid-WRITE: assert reset_n=0 while mem_wr_valid=1 -> all outputs 0 asynchronously; after release, state IDLE and no stq_pop for the abandoned store.

Source files
------------

// File: rtl/stq_commit_sequencer.sv
// Store-queue commit sequencer: drains retired head stores to the data memory
// write port, pulses the order-failure searcher, and requests a load-queue flush
// naming the oldest failing load when the searcher reports a violation.
module stq_commit_sequencer #(
  parameter int XLEN     = 32,
  parameter int LDQ_SIZE = 32,
  parameter int STQ_SIZE = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [$clog2(STQ_SIZE)-1:0] stq_head,
  input  logic                        stq_head_valid,
  input  logic                        stq_head_retired,
  input  logic [XLEN-1:0]             stq_head_address,
  input  logic [XLEN-1:0]             stq_head_data,
  output logic                        stq_pop,
  output logic                        mem_wr_valid,
  input  logic                        mem_wr_ready,
  output logic [XLEN-1:0]             mem_wr_addr,
  output logic [XLEN-1:0]             mem_wr_data,
  output logic                        stq_commit,
  output logic [$clog2(STQ_SIZE)-1:0] stq_commit_index,
  input  logic [LDQ_SIZE-1:0]         order_failures,
  input  logic [$clog2(LDQ_SIZE)-1:0] ldq_head,
  output logic                        ldq_flush_valid,
  output logic [$clog2(LDQ_SIZE)-1:0] ldq_flush_index,
  input  logic                        ldq_flush_ack,
  output logic                        busy,
  output logic [15:0]                 order_failure_count
);

  localparam int SW = $clog2(STQ_SIZE);
  localparam int LW = $clog2(LDQ_SIZE);
  localparam int unsigned LDQ_N = LDQ_SIZE;

  typedef enum logic [1:0] {IDLE, WRITE, CHECK, FLUSH} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SW-1:0]   r_idx;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_data;
  logic [LW-1:0]   r_flush_idx;
  logic [15:0]     r_fail_cnt;
  logic [LW-1:0]   w_best_idx;
  logic [LW-1:0]   w_best_dist;
  logic            w_found;
  logic            w_any_fail;

  assign w_any_fail = |order_failures;

  // Oldest failing load: smallest age distance (i - ldq_head) with natural LW-bit wrap.
  always_comb begin
    w_found     = 1'b0;
    w_best_idx  = '0;
    w_best_dist = '1;
    for (int unsigned i = 0; i < LDQ_N; i++) begin
      logic [LW-1:0] v_dist;
      v_dist = LW'(i) - ldq_head;
      if (order_failures[i] && (!w_found || (v_dist < w_best_dist))) begin
        w_found     = 1'b1;
        w_best_dist = v_dist;
        w_best_idx  = LW'(i);
      end
    end
  end

  // State register, head latches, flush index and saturating failure counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_flush_idx <= '0;
      r_fail_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && stq_head_valid && stq_head_retired) begin
        r_idx  <= stq_head;
        r_addr <= stq_head_address;
        r_data <= stq_head_data;
      end
      if ((r_state == CHECK) && w_any_fail) begin
        r_flush_idx <= w_best_idx;
        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 16'd1;
      end
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next          = r_state;
    mem_wr_valid    = 1'b0;
    stq_commit      = 1'b0;
    stq_pop         = 1'b0;
    ldq_flush_valid = 1'b0;
    case (r_state)
      IDLE:  if (stq_head_valid && stq_head_retired) w_next = WRITE;
      WRITE: begin
        mem_wr_valid = 1'b1;
        if (mem_wr_ready) w_next = CHECK;
      end
      CHECK: begin
        stq_commit = 1'b1;
        stq_pop    = 1'b1;
        w_next     = w_any_fail ? FLUSH : IDLE;
      end
      FLUSH: begin
        ldq_flush_valid = 1'b1;
        if (ldq_flush_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign mem_wr_addr         = r_addr;
  assign mem_wr_data         = r_data;
  assign stq_commit_index    = r_idx;
  assign ldq_flush_index     = r_flush_idx;
  assign busy                = (r_state != IDLE);
  assign order_failure_count = r_fail_cnt;

endmodule

// File: tb/tb_stq_commit_sequencer.sv
// Bench for stq_commit_sequencer: directed scenarios plus a randomized run where
// the bench plays the store queue and checks against an in-order store model.
module tb_stq_commit_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  stq_head;
  logic        stq_head_valid, stq_head_retired;
  logic [31:0] stq_head_address, stq_head_data;
  logic        stq_pop, mem_wr_valid, mem_wr_ready;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic        stq_commit;
  logic [4:0]  stq_commit_index;
  logic [31:0] order_failures;
  logic [4:0]  ldq_head;
  logic        ldq_flush_valid;
  logic [4:0]  ldq_flush_index;
  logic        ldq_flush_ack, busy;
  logic [15:0] order_failure_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] addr;
    logic [31:0] data;
  } store_t;

  stq_commit_sequencer #(.XLEN(32), .LDQ_SIZE(32), .STQ_SIZE(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .stq_head(stq_head), .stq_head_valid(stq_head_valid),
    .stq_head_retired(stq_head_retired), .stq_head_address(stq_head_address),
    .stq_head_data(stq_head_data), .stq_pop(stq_pop),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .stq_commit(stq_commit), .stq_commit_index(stq_commit_index),
    .order_failures(order_failures), .ldq_head(ldq_head),
    .ldq_flush_valid(ldq_flush_valid), .ldq_flush_index(ldq_flush_index),
    .ldq_flush_ack(ldq_flush_ack), .busy(busy),
    .order_failure_count(order_failure_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stq_head = '0; stq_head_valid = 1'b0; stq_head_retired = 1'b0;
    stq_head_address = '0; stq_head_data = '0; mem_wr_ready = 1'b0;
    order_failures = '0; ldq_head = '0; ldq_flush_ack = 1'b0;
  endtask

  task automatic present(input logic [4:0] idx, input logic [31:0] a, input logic [31:0] d);
    stq_head = idx; stq_head_address = a; stq_head_data = d;
    stq_head_valid = 1'b1; stq_head_retired = 1'b1;
  endtask

  // Reference: oldest failing load by modular age distance from the load-queue head.
  function automatic int oldest_fail(input logic [31:0] f, input int h);
    int best = -1;
    int bd = 1000;
    for (int i = 0; i < 32; i++) begin
      int d;
      d = (i - h + 32) % 32;
      if (f[i] && d < bd) begin bd = d; best = i; end
    end
    return best;
  endfunction

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({stq_pop, mem_wr_valid, stq_commit, ldq_flush_valid, busy} !== 5'b0 ||
        mem_wr_addr !== 32'h0 || mem_wr_data !== 32'h0 || stq_commit_index !== 5'h0 ||
        ldq_flush_index !== 5'h0 || order_failure_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: ctl=%b addr=%h data=%h idx=%0d fidx=%0d cnt=%0d required all zero",
               {stq_pop, mem_wr_valid, stq_commit, ldq_flush_valid, busy}, mem_wr_addr,
               mem_wr_data, stq_commit_index, ldq_flush_index, order_failure_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_single_store();
    present(5'd5, 32'h100, 32'hDEADBEEF);
    mem_wr_ready = 1'b1;
    tick();
    stq_head_valid = 1'b0;
    checks++;
    if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h100 || mem_wr_data !== 32'hDEADBEEF || stq_commit !== 1'b0) begin
      errors++;
      $display("FAIL single_write: valid=%b addr=%h data=%h commit=%b required 1 100 deadbeef 0",
               mem_wr_valid, mem_wr_addr, mem_wr_data, stq_commit);
    end
    tick();
    checks++;
    if (stq_commit !== 1'b1 || stq_pop !== 1'b1 || stq_commit_index !== 5'd5 || mem_wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_commit: commit=%b pop=%b idx=%0d wr_valid=%b required 1 1 5 0",
               stq_commit, stq_pop, stq_commit_index, mem_wr_valid);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || stq_commit !== 1'b0 || stq_pop !== 1'b0 || ldq_flush_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b commit=%b pop=%b flush=%b required 0 0 0 0",
               busy, stq_commit, stq_pop, ldq_flush_valid);
    end
  endtask

  task automatic test_backpressure();
    int vcyc = 0;
    present(5'd7, 32'hA000_0040, 32'h1234_5678);
    mem_wr_ready = 1'b0;
    tick();
    present(5'd9, 32'hBBBB_0000, 32'hCCCC_DDDD);
    for (int k = 0; k < 5; k++) begin
      mem_wr_ready = (k == 4);
      if (mem_wr_valid === 1'b1) vcyc++;
      checks++;
      if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'hA000_0040 || mem_wr_data !== 32'h1234_5678 || stq_commit !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d: valid=%b addr=%h data=%h commit=%b required 1 a0000040 12345678 0",
                 k, mem_wr_valid, mem_wr_addr, mem_wr_data, stq_commit);
      end
      tick();
    end
    stq_head_valid = 1'b0;
    mem_wr_ready = 1'b0;
    checks++;
    if (vcyc != 5 || stq_commit !== 1'b1 || stq_commit_index !== 5'd7 || mem_wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_commit: valid_cycles=%0d commit=%b idx=%0d wr_valid=%b required 5 1 7 0",
               vcyc, stq_commit, stq_commit_index, mem_wr_valid);
    end
    tick();
  endtask

  task automatic test_failure_wrap();
    ldq_head = 5'd30;
    present(5'd31, 32'h0000_0200, 32'h0BAD_F00D);
    mem_wr_ready = 1'b1;
    tick();
    stq_head_valid = 1'b0;
    tick();
    order_failures = (32'h1 << 2) | (32'h1 << 31);
    checks++;
    if (stq_commit !== 1'b1 || stq_commit_index !== 5'd31) begin
      errors++;
      $display("FAIL wrap_commit: commit=%b idx=%0d required 1 31", stq_commit, stq_commit_index);
    end
    exp_cnt++;
    tick();
    order_failures = '0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ldq_flush_valid !== 1'b1 || ldq_flush_index !== 5'd31 || order_failure_count !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL wrap_flush%0d: valid=%b idx=%0d cnt=%0d required 1 31 %0d",
                 k, ldq_flush_valid, ldq_flush_index, order_failure_count, exp_cnt);
      end
      tick();
    end
    ldq_flush_ack = 1'b1;
    tick();
    ldq_flush_ack = 1'b0;
    checks++;
    if (ldq_flush_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ack: flush_valid=%b busy=%b required 0 0", ldq_flush_valid, busy);
    end
    ldq_head = '0;
  endtask

  task automatic test_back_to_back();
    store_t s[3];
    int n = 0;
    int pops = 0;
    int ccyc[3];
    logic adv;
    for (int i = 0; i < 3; i++) begin
      s[i].idx = 5'(10 + i); s[i].addr = $urandom; s[i].data = $urandom;
    end
    mem_wr_ready = 1'b1;
    present(s[0].idx, s[0].addr, s[0].data);
    for (int cyc = 0; cyc < 12; cyc++) begin
      adv = 1'b0;
      if (stq_commit === 1'b1 && n < 3) begin
        ccyc[n] = cyc;
        checks++;
        if (stq_commit_index !== s[n].idx) begin
          errors++;
          $display("FAIL b2b_idx%0d: idx=%0d required %0d", n, stq_commit_index, s[n].idx);
        end
        n++;
      end
      if (stq_pop === 1'b1) begin pops++; adv = 1'b1; end
      tick();
      if (adv) begin
        if (pops < 3) present(s[pops].idx, s[pops].addr, s[pops].data);
        else stq_head_valid = 1'b0;
      end
    end
    checks++;
    if (n != 3 || pops != 3 || ccyc[0] != 2 || ccyc[1] != 5 || ccyc[2] != 8) begin
      errors++;
      $display("FAIL b2b_timing: commits=%0d pops=%0d at %0d,%0d,%0d required 3 3 at 2,5,8",
               n, pops, ccyc[0], ccyc[1], ccyc[2]);
    end
    mem_wr_ready = 1'b0;
  endtask

  task automatic test_flush_blocking();
    mem_wr_ready = 1'b1;
    present(5'd3, 32'h0000_0300, 32'h3333_3333);
    tick();
    tick();
    order_failures = 32'h0000_0010;
    exp_cnt++;
    tick();
    order_failures = '0;
    present(5'd4, 32'h0000_0400, 32'h4444_4444);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (mem_wr_valid !== 1'b0 || ldq_flush_valid !== 1'b1 || ldq_flush_index !== 5'd4) begin
        errors++;
        $display("FAIL fb_hold%0d: wr_valid=%b flush=%b fidx=%0d required 0 1 4",
                 k, mem_wr_valid, ldq_flush_valid, ldq_flush_index);
      end
      tick();
    end
    ldq_flush_ack = 1'b1;
    tick();
    ldq_flush_ack = 1'b0;
    checks++;
    if (mem_wr_valid !== 1'b0 || ldq_flush_valid !== 1'b0 || order_failure_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL fb_ackcycle: wr_valid=%b flush=%b cnt=%0d required 0 0 %0d",
               mem_wr_valid, ldq_flush_valid, order_failure_count, exp_cnt);
    end
    tick();
    checks++;
    if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h0000_0400) begin
      errors++;
      $display("FAIL fb_resume: wr_valid=%b addr=%h required 1 00000400", mem_wr_valid, mem_wr_addr);
    end
    stq_head_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_write();
    int bad = 0;
    present(5'd12, 32'h0000_0500, 32'h5555_5555);
    mem_wr_ready = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({stq_pop, mem_wr_valid, stq_commit, ldq_flush_valid, busy} !== 5'b0 ||
        mem_wr_addr !== 32'h0 || stq_commit_index !== 5'h0 || order_failure_count !== 16'h0) begin
      errors++;
      $display("FAIL rst_async: ctl=%b addr=%h idx=%0d cnt=%0d required all zero",
               {stq_pop, mem_wr_valid, stq_commit, ldq_flush_valid, busy}, mem_wr_addr,
               stq_commit_index, order_failure_count);
    end
    exp_cnt = 0;
    stq_head_valid = 1'b0;
    mem_wr_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (stq_pop !== 1'b0 || busy !== 1'b0 || mem_wr_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_after: %0d cycles with pop/busy/wr_valid set, required 0", bad);
    end
    mem_wr_ready = 1'b0;
  endtask

  task automatic test_random();
    store_t q[$];
    int total = 40;
    int done = 0;
    int exp_fidx = 0;
    logic flush_pend = 1'b0;
    logic wrote = 1'b0;
    logic do_pop, clr_flush;
    for (int i = 0; i < total; i++) begin
      store_t s;
      s.idx = 5'($urandom); s.addr = $urandom; s.data = $urandom;
      q.push_back(s);
    end
    for (int cyc = 0; cyc < 4000 && !(done == total && busy === 1'b0); cyc++) begin
      do_pop = 1'b0; clr_flush = 1'b0;
      checks++;
      if (stq_pop !== stq_commit || ldq_flush_valid !== flush_pend || order_failure_count !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL rnd_ctl c%0d: pop=%b commit=%b flush=%b cnt=%0d required pop==commit flush=%b cnt=%0d",
                 cyc, stq_pop, stq_commit, ldq_flush_valid, order_failure_count, flush_pend, exp_cnt);
      end
      if (flush_pend) begin
        checks++;
        if (ldq_flush_index !== 5'(exp_fidx) || mem_wr_valid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_flush c%0d: fidx=%0d wr_valid=%b required %0d 0",
                   cyc, ldq_flush_index, mem_wr_valid, exp_fidx);
        end
      end
      if (mem_wr_valid === 1'b1) begin
        checks++;
        if (q.size() == 0 || mem_wr_addr !== q[0].addr || mem_wr_data !== q[0].data) begin
          errors++;
          $display("FAIL rnd_write c%0d: addr=%h data=%h required head store (queue size %0d)",
                   cyc, mem_wr_addr, mem_wr_data, q.size());
        end
      end
      if (stq_commit === 1'b1) begin
        checks++;
        if (q.size() == 0 || !wrote || stq_commit_index !== q[0].idx) begin
          errors++;
          $display("FAIL rnd_commit c%0d: idx=%0d wrote=%b required idx=%0d after a write",
                   cyc, stq_commit_index, wrote, (q.size() != 0) ? q[0].idx : 0);
        end
        wrote = 1'b0;
        do_pop = 1'b1;
      end
      ldq_head = 5'($urandom);
      mem_wr_ready = ($urandom_range(0, 2) != 0);
      order_failures = '0;
      if (stq_commit === 1'b1 && $urandom_range(0, 1) == 1) begin
        order_failures = $urandom | 32'(1 << $urandom_range(0, 31));
        if ($urandom_range(0, 1) == 1) order_failures = 32'(1 << $urandom_range(0, 31));
        exp_fidx = oldest_fail(order_failures, int'(ldq_head));
        exp_cnt++;
      end
      ldq_flush_ack = flush_pend && ($urandom_range(0, 2) == 0);
      if (flush_pend && ldq_flush_ack) clr_flush = 1'b1;
      if (q.size() != 0) begin
        stq_head = q[0].idx; stq_head_address = q[0].addr; stq_head_data = q[0].data;
        stq_head_valid = 1'b1; stq_head_retired = ($urandom_range(0, 3) != 0);
      end else begin
        stq_head_valid = 1'b0; stq_head_retired = 1'b0;
      end
      if (mem_wr_valid === 1'b1 && mem_wr_ready) wrote = 1'b1;
      tick();
      if (order_failures != 0) flush_pend = 1'b1;
      if (clr_flush) flush_pend = 1'b0;
      if (do_pop && q.size() != 0) begin void'(q.pop_front()); done++; end
    end
    checks++;
    if (done != total || busy !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain: committed=%0d busy=%b required %0d 0", done, busy, total);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_store();
    test_backpressure();
    test_failure_wrap();
    test_back_to_back();
    test_flush_blocking();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
